// File: rtl/afifo_pkg.sv
// Shared types and helpers for the async-FIFO write-side arbiter.
package afifo_pkg;

    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned DATA_DEF  = 8;
    localparam int unsigned LEN_W_DEF = 4;
    localparam int unsigned NREQ_MAX  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1
    } state_t;

    // One-hot decode of a requester index; callers truncate to their NREQ.
    function automatic logic [NREQ_MAX-1:0] onehot(input logic [2:0] idx);
        logic [NREQ_MAX-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/afifo_wr_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or after i_rr_ptr, wrapping at NREQ.
module afifo_wr_arbiter_rr_pick #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_rr_ptr,
    output logic [IDX_W-1:0] o_pick,
    output logic             o_any_req
);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        o_pick    = '0;
        o_any_req = 1'b0;
        w_idx     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_idx = IDX_W'((32'(i_rr_ptr) + i) % NREQ);
            if (!o_any_req && i_req[w_idx]) begin
                o_any_req = 1'b1;
                o_pick    = w_idx;
            end
        end
    end

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO write port among NREQ requesters.
module afifo_wr_arbiter
    import afifo_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned DATA  = DATA_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] req_len,
    input  logic [NREQ*DATA-1:0]  req_data,
    input  logic                  wfull,
    output logic                  fifo_op,
    output logic [DATA-1:0]       fifo_wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  abort,
    output logic                  busy
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            r_state;
    logic [IDX_W-1:0]  r_gidx;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [LEN_W-1:0]  r_beat_cnt;
    logic [NREQ-1:0]   r_gnt;
    logic              r_abort;

    logic [LEN_W-1:0]  w_len  [NREQ];
    logic [DATA-1:0]   w_data [NREQ];
    logic [IDX_W-1:0]  w_pick;
    logic [IDX_W-1:0]  w_ptr_nxt;
    logic              w_any;
    logic              w_in_burst;
    logic              w_sel_req;
    logic              w_op;

    // Unpack the flat per-requester buses.
    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign w_len[k]  = req_len[k*LEN_W +: LEN_W];
        assign w_data[k] = req_data[k*DATA +: DATA];
    end

    afifo_wr_arbiter_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req     (req),
        .i_rr_ptr  (r_rr_ptr),
        .o_pick    (w_pick),
        .o_any_req (w_any)
    );

    assign w_ptr_nxt  = (w_pick == IDX_W'(NREQ - 1)) ? '0 : w_pick + IDX_W'(1);
    assign w_in_burst = (r_state == ST_BURST);
    assign w_sel_req  = req[r_gidx];
    // Never write while full; a dropped request ends the burst without a write.
    assign w_op       = w_in_burst & w_sel_req & ~wfull;

    assign fifo_op    = w_op;
    assign fifo_wdata = w_data[r_gidx];
    assign ack        = NREQ'(onehot(3'(r_gidx))) & {NREQ{w_op}};
    assign gnt        = r_gnt;
    assign abort      = r_abort;
    assign busy       = w_in_burst;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state    <= ST_IDLE;
            r_gidx     <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_gnt      <= '0;
            r_abort    <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_gnt <= '0;
                    if (w_any) begin
                        r_state    <= ST_BURST;
                        r_gidx     <= w_pick;
                        r_gnt      <= NREQ'(onehot(3'(w_pick)));
                        r_beat_cnt <= w_len[w_pick];
                        r_rr_ptr   <= w_ptr_nxt;
                    end
                end
                ST_BURST: begin
                    if (!w_sel_req) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                        r_abort <= 1'b1;
                    end else if (!wfull) begin
                        if (r_beat_cnt == '0) begin
                            r_state <= ST_IDLE;
                            r_gnt   <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt - LEN_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Bench for afifo_wr_arbiter: directed scenarios plus random traffic against a burst-level model.
module tb_afifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DATA  = 8;
    localparam int LEN_W = 4;

    logic                  clk;
    logic                  reset_b;
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ*DATA-1:0]  req_data;
    logic                  wfull;
    logic                  fifo_op;
    logic [DATA-1:0]       fifo_wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  abort;
    logic                  busy;

    afifo_wr_arbiter #(.NREQ(NREQ), .DATA(DATA), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .req        (req),
        .req_len    (req_len),
        .req_data   (req_data),
        .wfull      (wfull),
        .fifo_op    (fifo_op),
        .fifo_wdata (fifo_wdata),
        .gnt        (gnt),
        .ack        (ack),
        .abort      (abort),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int dut_wr  = 0;

    // Reference: who owns the port, how many beats remain, who is next in line.
    bit m_busy;
    int m_g;
    int m_left;
    int m_ptr;
    bit m_abort;
    bit done [NREQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_g     = 0;
        m_left  = 0;
        m_ptr   = 0;
        m_abort = 0;
    endtask

    task automatic set_len(input int k, input logic [LEN_W-1:0] v);
        req_len[k*LEN_W +: LEN_W] = v;
    endtask

    // Compare this cycle's outputs with the model, then advance the model across the next edge.
    task automatic check_cycle();
        logic [NREQ-1:0] e_gnt;
        logic            e_op;
        e_gnt = m_busy ? NREQ'(1 << m_g) : '0;
        e_op  = m_busy && req[m_g] && !wfull;
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("fifo_op", 32'(fifo_op), 32'(e_op));
        chk("ack", 32'(ack), e_op ? 32'(e_gnt) : 32'd0);
        chk("busy", 32'(busy), 32'(m_busy));
        chk("abort", 32'(abort), 32'(m_abort));
        if (e_op) chk("wdata", 32'(fifo_wdata), 32'(req_data[m_g*DATA +: DATA]));
        if (fifo_op) dut_wr++;

        m_abort = 0;
        if (m_busy) begin
            if (!req[m_g]) begin
                m_busy  = 0;
                m_abort = 1;
            end else if (!wfull) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy    = 0;
                    done[m_g] = 1;
                end
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                int j;
                j = (m_ptr + i) % NREQ;
                if (req[j]) begin
                    m_busy = 1;
                    m_g    = j;
                    m_left = int'(req_len[j*LEN_W +: LEN_W]) + 1;
                    m_ptr  = (j + 1) % NREQ;
                    break;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    // Requesters: hold req through a burst, sometimes drop mid-burst, sometimes re-request.
    task automatic drive_random();
        for (int k = 0; k < NREQ; k++) begin
            if (req[k]) begin
                if (done[k]) begin
                    done[k] = 0;
                    if ($urandom % 2 == 0) req[k] = 1'b0;
                end else if (m_busy && m_g == k && ($urandom % 30 == 0)) begin
                    req[k] = 1'b0;
                end
            end else if ($urandom % 3 == 0) begin
                req[k] = 1'b1;
            end
        end
        req_len  = NREQ*LEN_W'($urandom);
        req_data = NREQ*DATA'($urandom);
        wfull    = ($urandom % 4 == 0);
    endtask

    initial begin
        reset_b  = 1'b0;
        req      = '0;
        req_len  = '0;
        req_data = NREQ*DATA'($urandom);
        wfull    = 1'b0;
        model_reset();
        #12;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_op", 32'(fifo_op), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_abort", 32'(abort), 32'd0);
        chk("rst_wdata", 32'(fifo_wdata), 32'(req_data[DATA-1:0]));
        @(posedge clk);
        #1;
        reset_b = 1'b1;

        // Single 4-beat burst from requester 2.
        set_len(2, 4'd3);
        req    = 4'b0100;
        dut_wr = 0;
        repeat (5) tick();
        req = '0;
        tick();
        chk("single_wr", 32'(dut_wr), 32'd4);

        // All requesting, 1-beat bursts: rotation with one idle cycle between grants.
        req_len = '0;
        req     = 4'b1111;
        repeat (10) tick();
        req = '0;
        repeat (2) tick();

        // Full stall after the first beat.
        set_len(0, 4'd3);
        req    = 4'b0001;
        dut_wr = 0;
        tick();
        tick();
        wfull = 1'b1;
        repeat (3) tick();
        wfull = 1'b0;
        repeat (3) tick();
        req = '0;
        tick();
        chk("stall_wr", 32'(dut_wr), 32'd4);

        // Abort after 2 of 6 beats; next grant should go to requester 2.
        set_len(1, 4'd5);
        req    = 4'b0010;
        dut_wr = 0;
        repeat (3) tick();
        req = '0;
        repeat (2) tick();
        chk("abort_wr", 32'(dut_wr), 32'd2);
        req_len = '0;
        req     = 4'b1111;
        tick();
        chk("abort_next_gnt", 32'(gnt), 32'b0100);
        req = '0;
        repeat (2) tick();

        // Asynchronous reset during beat 3 of 8.
        set_len(2, 4'd7);
        req = 4'b0100;
        repeat (3) tick();
        reset_b = 1'b0;
        #1;
        chk("mid_rst_op", 32'(fifo_op), 32'd0);
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_abort", 32'(abort), 32'd0);
        model_reset();
        req_len = '0;
        req     = 4'b1111;
        #1;
        reset_b = 1'b1;
        tick();
        chk("rst_first_gnt", 32'(gnt), 32'b0001);
        req = '0;
        repeat (3) tick();

        // Longest burst, then rr_ptr wraps from 3 to 0.
        set_len(3, 4'hF);
        req    = 4'b1000;
        dut_wr = 0;
        repeat (17) tick();
        req = '0;
        tick();
        chk("max_len_wr", 32'(dut_wr), 32'd16);
        req_len = '0;
        req     = 4'b1111;
        tick();
        chk("wrap_gnt", 32'(gnt), 32'b0001);
        req = '0;
        repeat (3) tick();

        // Random traffic.
        for (int k = 0; k < NREQ; k++) done[k] = 0;
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/afifo_wr_arbiter.md
Name: afifo_wr_arbiter

Overview:
- Shares the single write port of the async FIFO among NREQ write-side requesters.
- Round-robin burst arbiter: grants one requester at a time and sequences its data beats into the FIFO.
- Drives the write pointer's op input and never issues a write while the FIFO reports full.
- Lives entirely in the write clock domain, between the requester blocks and the FIFO write pointer/memory.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATA, 8, FIFO data width.
- LEN_W, 4, burst-length field width; burst length L encodes L+1 beats (1..2^LEN_W).

Ports:
- clk  in  1  write-domain clock.
- reset_b  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester request; held high for the whole burst.
- req_len  in  NREQ*LEN_W  per-requester burst length (L = beats-1); slice k = bits [k*LEN_W +: LEN_W].
- req_data  in  NREQ*DATA  per-requester current beat data; slice k = bits [k*DATA +: DATA].
- wfull  in  1  FIFO full flag (the pointer's fifo_status).
- fifo_op  out  1  write strobe to the FIFO write pointer and memory.
- fifo_wdata  out  DATA  data to the FIFO memory.
- gnt  out  NREQ  one-hot grant, registered.
- ack  out  NREQ  one-hot beat accept; requester k advances to its next beat when ack[k]=1.
- abort  out  1  one-cycle pulse when a burst is abandoned.
- busy  out  1  high in BURST state.

Behaviour:
- States: IDLE, BURST (2-bit encoding). Registers:
  - state
  - gidx (granted index)
  - rr_ptr (requester with highest priority next)
  - beat_cnt (LEN_W bits)
  - abort
- Reset values: state=IDLE, gidx=0, rr_ptr=0, beat_cnt=0, gnt=0, abort=0. Combinational outputs then give fifo_op=0, ack=0, busy=0; fifo_wdata = req_data slice 0.
- IDLE:
  - If any req is high, pick the first requester at or after rr_ptr, searching upward with wrap at NREQ.
  - Register gidx=pick, gnt=onehot(pick), beat_cnt=req_len[pick], rr_ptr=(pick+1) mod NREQ.
  - Next state BURST; grant appears the cycle after req is seen.
  - If no req, stay in IDLE with gnt=0.
- BURST:
  - fifo_op = req[gidx] & ~wfull (combinational).
  - ack = onehot(gidx) & {NREQ{fifo_op}}.
  - fifo_wdata = req_data slice gidx.
  - Write accepted (fifo_op=1):
    - If beat_cnt==0, this is the last beat: go to IDLE and clear gnt.
    - Otherwise decrement beat_cnt.
  - wfull=1 with req[gidx]=1: stall; fifo_op=0, ack=0, beat_cnt held, stay in BURST indefinitely.
  - req[gidx]=0: abort. fifo_op=0, go to IDLE, clear gnt, assert abort for 1 cycle. Beats already written stay in the FIFO.
  - req_len changes during a burst are ignored; only the value latched at grant counts.
- Throughput:
  - One bubble cycle (IDLE) between consecutive bursts.
  - Within a burst, one beat per clk while not full.
  - Peak write rate is (L+1)/(L+2).
- Fairness:
  - rr_ptr advances past the winner on every grant, including grants that end in an abort.
  - Any continuously requesting requester is granted within NREQ grants.
- Full boundary:
  - fifo_op never asserts in a cycle with wfull=1.
  - The pointer's own full gating is redundant but must stay consistent with this block.
- Reset mid-burst: all registers return to reset values immediately (asynchronous); the partial burst is lost and abort is not pulsed.
- The grant is a single index; gnt and ack are never multi-hot.

Decomposition:
- Package afifo_pkg holds:
  - state encoding constants (ST_IDLE=0, ST_BURST=1)
  - default NREQ/DATA/LEN_W
  - a onehot function
- Sub-module rr_pick (combinational): inputs req, rr_ptr; outputs pick index and any_req. Implemented as a wrap-around priority search loop.
- The top level holds the FSM, beat counter and data mux.

Test Plan:
- Single burst: req[2]=1, req_len[2]=3, wfull=0. Expect gnt=4'b0100 one cycle later, then 4 cycles of fifo_op=1 with ack[2]=1, then IDLE; FIFO receives 4 words in order.
- Round-robin: req=4'b1111, all lengths 0. Expect grants in order 0,1,2,3,0, each a 1-beat write followed by 1 idle cycle; a new grant every 2 cycles.
- Full stall: 4-beat burst with wfull=1 held for 3 cycles after beat 1. Expect fifo_op=0 and ack=0 during the stall, beat_cnt frozen, and the remaining 3 beats written after wfull drops; total 4 writes, no duplicates.
- Abort: req[1] drops after 2 of 6 beats. Expect abort=1 for 1 cycle, return to IDLE, exactly 2 words written, and the next grant goes to the next requester after index 1.
- Reset mid-burst: reset_b low during beat 3 of 8. Expect fifo_op, gnt and busy all 0 immediately, rr_ptr=0 after release, and requester 0 wins first if req=4'b1111.
- Wrap/boundary: req_len=4'hF. Expect exactly 16 writes with no counter underflow; rr_ptr wraps from 3 to 0 after granting requester 3.
